// File: rtl/atm_pkg.sv
// Shared types and sizes for the ATM transaction controller.
// Latency: none (definitions only). Backpressure: none.
package atm_pkg;

    localparam int PIN_W          = 16;
    localparam int MONTO_W        = 32;
    localparam int BAL_W          = 64;
    localparam int MAX_INTENTOS   = 3;
    localparam int AVISO_INTENTOS = 2;

    typedef enum logic [2:0] {
        ESPERA_TARJETA,
        ESPERA_PIN,
        VERIFICA_PIN,
        ESPERA_MONTO,
        DEPOSITO,
        RETIRO,
        BLOQUEADO
    } state_t;

endpackage

// File: rtl/atm_controller_stb_rise_det.sv
// Strobe register plus rising-edge event: one event per strobe, however long it is held.
// Latency: event is combinational from stb; 1-cycle history register. Backpressure: none.
module stb_rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic stb,
    output logic evt
);

    logic stb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_q <= 1'b0;
        end else begin
            stb_q <= stb;
        end
    end

    assign evt = stb & ~stb_q;

endmodule

// File: rtl/atm_controller.sv
// ATM session controller: card, 4-digit BCD PIN with 3-try lockout, one deposit/withdrawal.
// Latency: results registered 1 cycle after the decision state. Backpressure: none; strobes are edge events.
// Optional inactivity timeout in the waiting states is built when ATM_TIMEOUT_EN is defined.
module atm_controller
    import atm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                TARJETA_RECIBIDA,
    input  logic                DIGITO_STB,
    input  logic [3:0]          DIGITO,
    input  logic [PIN_W-1:0]    PIN_CORRECTO,
    input  logic                TIPO_TRANS,
    input  logic                MONTO_STB,
    input  logic [MONTO_W-1:0]  MONTO,
    input  logic [BAL_W-1:0]    BALANCE_INICIAL,
    output logic [BAL_W-1:0]    BALANCE,
    output logic                BALANCE_ACTUALIZADO,
    output logic                ENTREGAR_DINERO,
    output logic                FONDOS_INSUFICIENTES,
    output logic                PIN_INCORRECTO,
    output logic                ADVERTENCIA,
    output logic                BLOQUEO,
    output logic                TIMEOUT
);

    state_t               state, state_d;
    logic [PIN_W-1:0]     pin_reg, pin_d;
    logic [1:0]           dig_cnt, dig_cnt_d;
    logic [1:0]           intentos, intentos_d;
    logic [MONTO_W-1:0]   monto_reg, monto_d;
    logic                 cargado;
    logic [BAL_W-1:0]     bal_d;
    logic                 act_d, ent_d, fond_d, pin_inc_d, adv_d, blq_d, to_d;
    logic                 dig_evt, monto_evt;
    logic [BAL_W-1:0]     monto_ext;

    assign monto_ext = {{(BAL_W-MONTO_W){1'b0}}, monto_reg};

    stb_rise_det u_dig_det (
        .clk   (CLK),
        .rst_n (RESET),
        .stb   (DIGITO_STB),
        .evt   (dig_evt)
    );

    stb_rise_det u_monto_det (
        .clk   (CLK),
        .rst_n (RESET),
        .stb   (MONTO_STB),
        .evt   (monto_evt)
    );

`ifdef ATM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] idle_cnt, idle_d;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_d;
        end
    end
`endif

    always_comb begin
        state_d    = state;
        pin_d      = pin_reg;
        dig_cnt_d  = dig_cnt;
        intentos_d = intentos;
        monto_d    = monto_reg;
        bal_d      = BALANCE;
        act_d      = 1'b0;
        ent_d      = 1'b0;
        fond_d     = 1'b0;
        pin_inc_d  = 1'b0;
        adv_d      = ADVERTENCIA;
        blq_d      = BLOQUEO;
        to_d       = 1'b0;

        case (state)
            ESPERA_TARJETA: begin
                if (TARJETA_RECIBIDA) begin
                    state_d   = ESPERA_PIN;
                    dig_cnt_d = 2'd0;
                end
            end
            ESPERA_PIN: begin
                if (dig_evt) begin
                    pin_d     = {pin_reg[PIN_W-5:0], DIGITO};
                    dig_cnt_d = dig_cnt + 2'd1;
                    if (dig_cnt == 2'd3) begin
                        state_d = VERIFICA_PIN;
                    end
                end
            end
            VERIFICA_PIN: begin
                dig_cnt_d = 2'd0;
                if (pin_reg == PIN_CORRECTO) begin
                    state_d    = ESPERA_MONTO;
                    intentos_d = 2'd0;
                    adv_d      = 1'b0;
                end else begin
                    pin_inc_d  = 1'b1;
                    intentos_d = intentos + 2'd1;
                    if (intentos_d == 2'(MAX_INTENTOS)) begin
                        blq_d   = 1'b1;
                        state_d = BLOQUEADO;
                    end else begin
                        if (intentos_d == 2'(AVISO_INTENTOS)) begin
                            adv_d = 1'b1;
                        end
                        state_d = ESPERA_PIN;
                    end
                end
            end
            ESPERA_MONTO: begin
                if (monto_evt) begin
                    monto_d = MONTO;
                    state_d = TIPO_TRANS ? RETIRO : DEPOSITO;
                end
            end
            DEPOSITO: begin
                bal_d   = BALANCE + monto_ext;
                act_d   = 1'b1;
                state_d = ESPERA_TARJETA;
            end
            RETIRO: begin
                if (monto_ext <= BALANCE) begin
                    bal_d = BALANCE - monto_ext;
                    act_d = 1'b1;
                    ent_d = 1'b1;
                end else begin
                    fond_d = 1'b1;
                end
                state_d = ESPERA_TARJETA;
            end
            BLOQUEADO: begin
                blq_d = 1'b1;
            end
            default: begin
                state_d = ESPERA_TARJETA;
            end
        endcase

`ifdef ATM_TIMEOUT_EN
        // Non-waiting states hold the counter at zero, so entry always starts a fresh count.
        idle_d = '0;
        if ((state == ESPERA_PIN || state == ESPERA_MONTO) && !dig_evt && !monto_evt) begin
            if (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                to_d      = 1'b1;
                state_d   = ESPERA_TARJETA;
                dig_cnt_d = 2'd0;
            end else begin
                idle_d = idle_cnt + 1'b1;
            end
        end
`endif

        // The opening balance is loaded once, silently, on the first edge out of reset.
        if (!cargado) begin
            bal_d = BALANCE_INICIAL;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state                <= ESPERA_TARJETA;
            pin_reg              <= '0;
            dig_cnt              <= 2'd0;
            intentos             <= 2'd0;
            monto_reg            <= '0;
            cargado              <= 1'b0;
            BALANCE              <= '0;
            BALANCE_ACTUALIZADO  <= 1'b0;
            ENTREGAR_DINERO      <= 1'b0;
            FONDOS_INSUFICIENTES <= 1'b0;
            PIN_INCORRECTO       <= 1'b0;
            ADVERTENCIA          <= 1'b0;
            BLOQUEO              <= 1'b0;
            TIMEOUT              <= 1'b0;
        end else begin
            state                <= state_d;
            pin_reg              <= pin_d;
            dig_cnt              <= dig_cnt_d;
            intentos             <= intentos_d;
            monto_reg            <= monto_d;
            cargado              <= 1'b1;
            BALANCE              <= bal_d;
            BALANCE_ACTUALIZADO  <= act_d;
            ENTREGAR_DINERO      <= ent_d;
            FONDOS_INSUFICIENTES <= fond_d;
            PIN_INCORRECTO       <= pin_inc_d;
            ADVERTENCIA          <= adv_d;
            BLOQUEO              <= blq_d;
            TIMEOUT              <= to_d;
        end
    end

endmodule

// File: tb/tb_atm_controller.sv
// Self-checking bench for atm_controller: directed plan scenarios plus randomized sessions
// against a session-level reference model (balance, attempts, lock) kept in the bench.
module tb_atm_controller;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        TARJETA_RECIBIDA = 1'b0;
    logic        DIGITO_STB = 1'b0;
    logic [3:0]  DIGITO = 4'd0;
    logic [15:0] PIN_CORRECTO = 16'h3566;
    logic        TIPO_TRANS = 1'b0;
    logic        MONTO_STB = 1'b0;
    logic [31:0] MONTO = 32'd0;
    logic [63:0] BALANCE_INICIAL = 64'd0;
    logic [63:0] BALANCE;
    logic        BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES;
    logic        PIN_INCORRECTO, ADVERTENCIA, BLOQUEO, TIMEOUT;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [63:0] m_bal;
    int          m_att;
    bit          m_warn, m_lock, m_monto;

    // Pulse-cycle counters sampled at each rising edge
    int n_act = 0, n_ent = 0, n_fond = 0, n_pinc = 0, n_to = 0, n_both = 0;

    atm_controller #(.TIMEOUT_CYCLES(16)) dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .TARJETA_RECIBIDA     (TARJETA_RECIBIDA),
        .DIGITO_STB           (DIGITO_STB),
        .DIGITO               (DIGITO),
        .PIN_CORRECTO         (PIN_CORRECTO),
        .TIPO_TRANS           (TIPO_TRANS),
        .MONTO_STB            (MONTO_STB),
        .MONTO                (MONTO),
        .BALANCE_INICIAL      (BALANCE_INICIAL),
        .BALANCE              (BALANCE),
        .BALANCE_ACTUALIZADO  (BALANCE_ACTUALIZADO),
        .ENTREGAR_DINERO      (ENTREGAR_DINERO),
        .FONDOS_INSUFICIENTES (FONDOS_INSUFICIENTES),
        .PIN_INCORRECTO       (PIN_INCORRECTO),
        .ADVERTENCIA          (ADVERTENCIA),
        .BLOQUEO              (BLOQUEO),
        .TIMEOUT              (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (BALANCE_ACTUALIZADO === 1'b1) n_act++;
        if (ENTREGAR_DINERO === 1'b1) n_ent++;
        if (FONDOS_INSUFICIENTES === 1'b1) n_fond++;
        if (PIN_INCORRECTO === 1'b1) n_pinc++;
        if (TIMEOUT === 1'b1) n_to++;
        if (BALANCE_ACTUALIZADO === 1'b1 && ENTREGAR_DINERO === 1'b1) n_both++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_digit(input logic [3:0] d, input int hold);
        DIGITO = d;
        DIGITO_STB = 1'b1;
        repeat (hold) tick();
        DIGITO_STB = 1'b0;
        DIGITO = 4'($urandom_range(0, 9));
        tick();
    endtask

    task automatic card_in();
        TARJETA_RECIBIDA = 1'b1;
        tick();
        TARJETA_RECIBIDA = 1'b0;
        tick();
    endtask

    // Model of one PIN attempt followed by the resulting outputs
    task automatic do_pin(input logic [15:0] p, input int hold0);
        int pinc0, exp_inc;
        pinc0 = n_pinc;
        exp_inc = 0;
        card_in();
        for (int i = 0; i < 4; i++) send_digit(p[15-4*i -: 4], (i == 0) ? hold0 : 1);
        tick();
        if (!m_lock) begin
            if (p == PIN_CORRECTO) begin
                m_att = 0;
                m_warn = 0;
                m_monto = 1;
            end else begin
                exp_inc = 1;
                m_att++;
                if (m_att == 2) m_warn = 1;
                if (m_att >= 3) m_lock = 1;
            end
        end
        checks++;
        if (n_pinc - pinc0 !== exp_inc) begin
            errors++;
            $display("FAIL pin_incorrecto pin=%h: pulses=%0d expected=%0d", p, n_pinc - pinc0, exp_inc);
        end
        checks++;
        if (BLOQUEO !== m_lock) begin
            errors++;
            $display("FAIL bloqueo pin=%h: got=%b expected=%b", p, BLOQUEO, m_lock);
        end
        if (!m_lock) begin
            checks++;
            if (ADVERTENCIA !== m_warn) begin
                errors++;
                $display("FAIL advertencia pin=%h: got=%b expected=%b", p, ADVERTENCIA, m_warn);
            end
        end
    endtask

    // Model of one amount strobe; TIPO_TRANS/MONTO are scrambled after the event edge
    task automatic do_amount(input logic tipo, input logic [31:0] amt, input int hold);
        int a0, e0, f0, b0;
        int exp_act, exp_ent, exp_fond;
        a0 = n_act; e0 = n_ent; f0 = n_fond; b0 = n_both;
        exp_act = 0; exp_ent = 0; exp_fond = 0;
        MONTO = amt;
        TIPO_TRANS = tipo;
        MONTO_STB = 1'b1;
        tick();
        TIPO_TRANS = ~tipo;
        MONTO = $urandom;
        repeat (hold - 1) tick();
        MONTO_STB = 1'b0;
        tick();
        tick();
        if (m_monto && !m_lock) begin
            if (!tipo) begin
                m_bal = m_bal + {32'd0, amt};
                exp_act = 1;
            end else if ({32'd0, amt} <= m_bal) begin
                m_bal = m_bal - {32'd0, amt};
                exp_act = 1;
                exp_ent = 1;
            end else begin
                exp_fond = 1;
            end
            m_monto = 0;
        end
        checks++;
        if (BALANCE !== m_bal) begin
            errors++;
            $display("FAIL balance tipo=%b monto=%0d: got=%0d expected=%0d", tipo, amt, BALANCE, m_bal);
        end
        checks++;
        if (n_act - a0 !== exp_act || n_ent - e0 !== exp_ent || n_fond - f0 !== exp_fond) begin
            errors++;
            $display("FAIL pulses tipo=%b monto=%0d: act/ent/fond=%0d/%0d/%0d expected=%0d/%0d/%0d",
                     tipo, amt, n_act - a0, n_ent - e0, n_fond - f0, exp_act, exp_ent, exp_fond);
        end
        checks++;
        if (n_both - b0 !== exp_ent) begin
            errors++;
            $display("FAIL same_cycle act+ent: got=%0d expected=%0d", n_both - b0, exp_ent);
        end
    endtask

    task automatic do_reset(input logic [63:0] init);
        int a0;
        DIGITO_STB = 1'b0;
        MONTO_STB = 1'b0;
        TARJETA_RECIBIDA = 1'b0;
        BALANCE_INICIAL = init;
        RESET = 1'b0;
        tick();
        tick();
        checks++;
        if ({BALANCE, BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES,
             PIN_INCORRECTO, ADVERTENCIA, BLOQUEO, TIMEOUT} !== 71'd0) begin
            errors++;
            $display("FAIL reset_outputs: balance=%0d flags=%b%b%b%b%b%b%b expected all 0", BALANCE,
                     BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES,
                     PIN_INCORRECTO, ADVERTENCIA, BLOQUEO, TIMEOUT);
        end
        RESET = 1'b1;
        a0 = n_act;
        tick();
        tick();
        m_bal = init;
        m_att = 0;
        m_warn = 0;
        m_lock = 0;
        m_monto = 0;
        checks++;
        if (BALANCE !== m_bal || n_act - a0 !== 0) begin
            errors++;
            $display("FAIL reset_load: balance=%0d act_pulses=%0d expected balance=%0d pulses=0",
                     BALANCE, n_act - a0, m_bal);
        end
    endtask

    task automatic test_reset();
        do_reset(64'd0);
    endtask

    task automatic test_deposit();
        PIN_CORRECTO = 16'h3566;
        do_pin(16'h3566, 1);
        do_amount(1'b0, 32'd10000, 1);
    endtask

    task automatic test_withdraw();
        do_pin(16'h3566, 1);
        do_amount(1'b1, 32'd7000, 1);
    endtask

    task automatic test_lockout();
        do_pin(16'h3561, 1);
        do_pin(16'h1111, 1);
        do_pin(16'h1534, 1);
        do_pin(16'h3566, 1);
        do_amount(1'b0, 32'd500, 1);
    endtask

    task automatic test_unlock();
        do_reset(64'd0);
        do_pin(16'h3566, 1);
        do_amount(1'b0, 32'd10000, 1);
    endtask

    task automatic test_refused();
        do_pin(16'h3566, 1);
        do_amount(1'b1, 32'd900000, 1);
        do_pin(16'h3566, 1);
        do_amount(1'b1, 32'd10000, 1);
    endtask

    task automatic test_strobe_hold();
        do_pin(16'h3566, 3);
        send_digit(4'd7, 1);
        do_amount(1'b0, 32'd1234, 3);
    endtask

    task automatic test_mid_reset();
        do_pin(16'h1111, 1);
        do_pin(16'h2222, 1);
        card_in();
        send_digit(4'd9, 1);
        send_digit(4'd9, 1);
        do_reset(64'd5000);
        do_pin(16'h0000, 1);
        do_pin(16'h3566, 1);
        do_amount(1'b1, 32'd5000, 1);
    endtask

    task automatic test_timeout();
        int t0;
        t0 = n_to;
        card_in();
        send_digit(4'd3, 1);
        send_digit(4'd5, 1);
`ifdef ATM_TIMEOUT_EN
        repeat (14) tick();
        checks++;
        if (TIMEOUT !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got=%b expected=0", TIMEOUT);
        end
        tick();
        checks++;
        if (TIMEOUT !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pulse: got=%b expected=1", TIMEOUT);
        end
        tick();
        checks++;
        if (n_to - t0 !== 1) begin
            errors++;
            $display("FAIL timeout_count: pulses=%0d expected=1", n_to - t0);
        end
        do_pin(16'h3566, 1);
        do_amount(1'b0, 32'd1, 1);
`else
        repeat (40) tick();
        checks++;
        if (n_to - t0 !== 0) begin
            errors++;
            $display("FAIL timeout_disabled: pulses=%0d expected=0", n_to - t0);
        end
        t0 = n_pinc;
        send_digit(4'd6, 1);
        send_digit(4'd6, 1);
        tick();
        checks++;
        if (n_pinc - t0 !== 0) begin
            errors++;
            $display("FAIL slow_pin: pin_incorrecto pulses=%0d expected=0", n_pinc - t0);
        end
        m_att = 0;
        m_warn = 0;
        m_monto = 1;
        do_amount(1'b0, 32'd1, 1);
`endif
    endtask

    task automatic test_wrap();
        do_reset(64'hFFFF_FFFF_FFFF_FFF0);
        do_pin(16'h3566, 1);
        do_amount(1'b0, 32'h20, 1);
    endtask

    task automatic test_random();
        logic [15:0] p;
        logic [31:0] amt;
        do_reset({28'd0, 4'($urandom_range(0, 15)), 32'($urandom)});
        for (int i = 0; i < 4; i++) PIN_CORRECTO[15-4*i -: 4] = 4'($urandom_range(0, 9));
        for (int it = 0; it < 40; it++) begin
            if (m_lock) do_reset({32'd0, 32'($urandom)});
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < 4; i++) p[15-4*i -: 4] = 4'($urandom_range(0, 9));
                if (p == PIN_CORRECTO) p[3:0] = (p[3:0] == 4'd9) ? 4'd0 : p[3:0] + 4'd1;
                do_pin(p, 1);
            end else begin
                do_pin(PIN_CORRECTO, $urandom_range(1, 3));
                case ($urandom_range(0, 2))
                    0: amt = $urandom;
                    1: amt = (m_bal[63:32] == 32'd0) ? m_bal[31:0] : 32'hFFFF_FFFF;
                    default: amt = $urandom_range(0, 1000);
                endcase
                do_amount(1'($urandom_range(0, 1)), amt, $urandom_range(1, 2));
            end
        end
    endtask

    initial begin
        m_bal = 64'd0;
        m_att = 0;
        m_warn = 0;
        m_lock = 0;
        m_monto = 0;
        test_reset();
        test_deposit();
        test_withdraw();
        test_lockout();
        test_unlock();
        test_refused();
        test_strobe_hold();
        test_mid_reset();
        test_timeout();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
